if_id_buf: RTL and testbench
============================

IF_ID_BUF -- requirements
Module: if_id_buf

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC width in bits.
REQ-002 SHALL have parameter INST_W, default 32, instruction width in bits.
REQ-003 SHALL have parameter DEPTH, default 2, number of entries; power of two, >= 2.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port flush  input  1  discard all buffered and in-flight instructions.
REQ-007 SHALL have port if_valid  input  1  fetch offers if_pc/if_inst this cycle.
REQ-008 SHALL have port if_ready  output  1  buffer accepts the offer this cycle.
REQ-009 SHALL have port if_pc  input  ADDR_W  fetched PC.
REQ-010 SHALL have port if_inst  input  INST_W  fetched instruction.
REQ-011 SHALL have port id_valid  output  1  head entry presented to decode.
REQ-012 SHALL have port id_ready  input  1  decode consumes head this cycle.
REQ-013 SHALL have port id_pc  output  ADDR_W  head PC.
REQ-014 SHALL have port id_inst  output  INST_W  head instruction.
REQ-015 SHALL have port count  output  $clog2(DEPTH+1)  current occupancy.

Function
REQ-016 SHALL store entries in a circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits, wrapping DEPTH-1 -> 0.
REQ-017 SHALL define push = if_valid & if_ready, pop = id_valid & id_ready.
REQ-018 SHALL drive if_ready = (count < DEPTH) & ~flush; no pass-through when full.
REQ-019 SHALL drive id_valid = (count != 0) & ~flush.
REQ-020 SHALL present head entry on id_pc/id_inst when id_valid=1; both all-zero (NOP) when id_valid=0.
REQ-021 SHALL make an accepted entry visible on id_* exactly one cycle after push (no same-cycle bypass).
REQ-022 SHALL on push write entry at wr_ptr and advance wr_ptr; on pop advance rd_ptr.
REQ-023 SHALL on simultaneous push and pop keep count unchanged and preserve order.
REQ-024 SHALL hold head stable while id_valid=1 and id_ready=0.
REQ-025 SHALL treat id_ready while id_valid=0 as no-op; if_valid while if_ready=0 as no-op.
REQ-026 SHALL on flush clear count, wr_ptr, rd_ptr at the next edge; no push or pop occurs in the flush cycle.
REQ-027 SHALL give flush priority over push/pop; rst priority over flush.
REQ-028 SHALL never overflow or underflow count under any input sequence.

Reset
REQ-029 SHALL on rst=1 at a rising edge clear count, wr_ptr, rd_ptr and (with exception tags) all tag bits.
REQ-030 SHALL after reset present id_valid=0, id_pc=0, id_inst=0, if_ready=1, count=0.
REQ-031 SHALL need no reset of storage array data; outputs are gated by id_valid.
REQ-032 SHALL discard all entries when rst asserts mid-operation, identical to flush.

Configuration
REQ-033 SHALL use macro IF_ID_EXCTAG_EN to compile in exception tagging.
REQ-034 SHALL with IF_ID_EXCTAG_EN defined add ports if_exc input 1 and id_exc output 1, stored per entry alongside pc/inst, id_exc=0 when id_valid=0.
REQ-035 SHALL with IF_ID_EXCTAG_EN undefined have neither port nor storage; behaviour otherwise identical.

Verification
REQ-036 SHALL cover reset: rst=1 one edge with 2 entries stored -> count=0, id_valid=0, id_pc=0, id_inst=0, if_ready=1.
REQ-037 SHALL cover fill: DEPTH=2, id_ready=0, push pc 0x100/0x104 -> count=2, if_ready=0, third offer 0x108 not accepted, head 0x100 held.
REQ-038 SHALL cover streaming: if_valid=1, id_ready=1 continuous, pcs 0x0,0x4,0x8.. -> id_pc lags if_pc by one cycle, count stays 1, no gaps.
REQ-039 SHALL cover wrap: DEPTH=4, 10 pushes with interleaved pops -> in-order output 0x0..0x24 across pointer wrap.
REQ-040 SHALL cover flush: count=2, flush=1 with if_valid=1 and id_ready=1 -> that cycle if_ready=0, id_valid=0; next cycle count=0, no entry lost-then-reappears.
REQ-041 SHALL cover IF_ID_EXCTAG_EN: push if_exc=1 with pc 0x200 -> id_exc=1 only while id_pc=0x200 is at head.

Source files
------------

// File: rtl/if_id_buf.sv
// rtl/if_id_buf.sv - Fetch-to-decode instruction buffer (circular queue between IF and ID)
//
// Purpose: holds up to DEPTH fetched {pc, inst} entries between the fetch and
// decode stages. An accepted entry appears at the decode side one cycle after
// it is pushed; there is no same-cycle bypass and no pass-through when full.
//
// Optional feature macro: IF_ID_EXCTAG_EN
//   When defined, a one-bit exception tag (if_exc -> id_exc) is stored with
//   each entry. When undefined, neither the ports nor the storage exist.
//
// Ports:
//   clk        in   rising-edge clock for all state
//   rst        in   synchronous active-high reset (priority over flush)
//   flush      in   drops every buffered entry; blocks push/pop this cycle
//   if_valid   in   fetch offers if_pc/if_inst (and if_exc) this cycle
//   if_ready   out  buffer accepts the offer this cycle
//   if_pc      in   fetched PC
//   if_inst    in   fetched instruction
//   if_exc     in   exception tag of fetched entry   (IF_ID_EXCTAG_EN only)
//   id_valid   out  head entry is presented to decode
//   id_ready   in   decode consumes the head this cycle
//   id_pc      out  head PC, zero when id_valid=0
//   id_inst    out  head instruction, zero (NOP) when id_valid=0
//   id_exc     out  head exception tag, zero when id_valid=0 (IF_ID_EXCTAG_EN only)
//   count      out  current occupancy

module if_id_buf #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       if_valid,
    output logic                       if_ready,
    input  logic [ADDR_W-1:0]          if_pc,
    input  logic [INST_W-1:0]          if_inst,
`ifdef IF_ID_EXCTAG_EN
    input  logic                       if_exc,
    output logic                       id_exc,
`endif
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [ADDR_W-1:0]          id_pc,
    output logic [INST_W-1:0]          id_inst,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(DEPTH - 1);

    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;

    // Storage array is never reset; all reads are gated by id_valid.
    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];
    logic [INST_W-1:0] r_inst_mem [DEPTH];
`ifdef IF_ID_EXCTAG_EN
    logic              r_exc_mem  [DEPTH];
`endif

    logic w_if_ready;
    logic w_id_valid;
    logic w_push;
    logic w_pop;

    // Readiness is derived from registered occupancy only, so a full buffer
    // cannot accept even when decode is popping in the same cycle.
    assign w_if_ready = (r_count < DEPTH_C) & ~flush;
    assign w_id_valid = (r_count != '0) & ~flush;
    assign w_push     = if_valid & w_if_ready;
    assign w_pop      = w_id_valid & id_ready;

    assign if_ready = w_if_ready;
    assign id_valid = w_id_valid;
    assign count    = r_count;

    assign id_pc   = w_id_valid ? r_pc_mem[r_rd_ptr]   : '0;
    assign id_inst = w_id_valid ? r_inst_mem[r_rd_ptr] : '0;
`ifdef IF_ID_EXCTAG_EN
    assign id_exc  = w_id_valid ? r_exc_mem[r_rd_ptr]  : 1'b0;
`endif

    // Control state: rst beats flush, flush beats push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= (r_wr_ptr == LAST_C) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == LAST_C) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Data path: w_push already excludes rst-free flush cycles; rst is
    // checked too so a reset edge never writes a stray entry.
    always_ff @(posedge clk) begin
        if (w_push && !rst) begin
            r_pc_mem[r_wr_ptr]   <= if_pc;
            r_inst_mem[r_wr_ptr] <= if_inst;
`ifdef IF_ID_EXCTAG_EN
            r_exc_mem[r_wr_ptr]  <= if_exc;
`endif
        end
    end

endmodule

// File: tb/tb_if_id_buf.sv
// tb/tb_if_id_buf.sv - Randomized self-checking bench for if_id_buf (DEPTH=2 and DEPTH=4)

module tb_if_id_buf;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        if_valid;
    logic        id_ready;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_exc;

    logic        if_ready2, id_valid2;
    logic [31:0] id_pc2, id_inst2;
    logic [1:0]  count2;
    logic        if_ready4, id_valid4;
    logic [31:0] id_pc4, id_inst4;
    logic [2:0]  count4;
`ifdef IF_ID_EXCTAG_EN
    logic        id_exc2, id_exc4;
`endif

    int   checks;
    int   errors;
    ent_t q2[$];
    ent_t q4[$];

    if_id_buf #(.ADDR_W(32), .INST_W(32), .DEPTH(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready2),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
`ifdef IF_ID_EXCTAG_EN
        .if_exc   (if_exc),
        .id_exc   (id_exc2),
`endif
        .id_valid (id_valid2),
        .id_ready (id_ready),
        .id_pc    (id_pc2),
        .id_inst  (id_inst2),
        .count    (count2)
    );

    if_id_buf #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) u_dut4 (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .if_valid (if_valid),
        .if_ready (if_ready4),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
`ifdef IF_ID_EXCTAG_EN
        .if_exc   (if_exc),
        .id_exc   (id_exc4),
`endif
        .id_valid (id_valid4),
        .id_ready (id_ready),
        .id_pc    (id_pc4),
        .id_inst  (id_inst4),
        .count    (count4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a bounded FIFO per depth. Acceptance uses occupancy
    // before the edge (no pass-through when full); rst/flush empty it.
    task automatic tick();
        ent_t e;
        bit   pu2, po2, pu4, po4;
        @(posedge clk);
        e.pc   = if_pc;
        e.inst = if_inst;
        e.exc  = if_exc;
        if (rst || flush) begin
            q2.delete();
            q4.delete();
        end else begin
            pu2 = if_valid && (q2.size() < 2);
            po2 = id_ready && (q2.size() != 0);
            pu4 = if_valid && (q4.size() < 4);
            po4 = id_ready && (q4.size() != 0);
            if (po2) void'(q2.pop_front());
            if (pu2) q2.push_back(e);
            if (po4) void'(q4.pop_front());
            if (pu4) q4.push_back(e);
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst      = 1'b0;
        flush    = 1'b0;
        if_valid = 1'b0;
        id_ready = 1'b0;
        if_pc    = '0;
        if_inst  = '0;
        if_exc   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 5;
        if (count4 !== 3'd0)   begin errors++; $display("FAIL reset_count: got %0d expected 0", count4); end
        if (id_valid4 !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid4); end
        if (id_pc4 !== 32'h0)   begin errors++; $display("FAIL reset_id_pc: got %h expected 0", id_pc4); end
        if (id_inst4 !== 32'h0) begin errors++; $display("FAIL reset_id_inst: got %h expected 0", id_inst4); end
        if (if_ready4 !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b expected 1", if_ready4); end
        // Store two entries, then reset mid-operation.
        if_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            if_pc   = 32'h40 + 32'(i * 4);
            if_inst = $urandom;
            tick();
        end
        if_valid = 1'b0;
        #1;
        checks++;
        if (count2 !== 2'd2) begin errors++; $display("FAIL reset_prefill_count: got %0d expected 2", count2); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        checks += 6;
        if (count2 !== 2'd0)    begin errors++; $display("FAIL reset2_count: got %0d expected 0", count2); end
        if (id_valid2 !== 1'b0) begin errors++; $display("FAIL reset2_id_valid: got %b expected 0", id_valid2); end
        if (id_pc2 !== 32'h0)   begin errors++; $display("FAIL reset2_id_pc: got %h expected 0", id_pc2); end
        if (id_inst2 !== 32'h0) begin errors++; $display("FAIL reset2_id_inst: got %h expected 0", id_inst2); end
        if (if_ready2 !== 1'b1) begin errors++; $display("FAIL reset2_if_ready: got %b expected 1", if_ready2); end
        if (count4 !== 3'd0)    begin errors++; $display("FAIL reset2_count4: got %0d expected 0", count4); end
    endtask

    task automatic test_fill();
        logic [31:0] pcs [3];
        pcs[0] = 32'h100;
        pcs[1] = 32'h104;
        pcs[2] = 32'h108;
        do_reset();
        if_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_pc   = pcs[i];
            if_inst = $urandom;
            #1;
            checks += 2;
            if (if_ready2 !== (i < 2)) begin errors++; $display("FAIL fill_if_ready[%0d]: got %b expected %b", i, if_ready2, (i < 2)); end
            if (id_valid2 !== (i > 0)) begin errors++; $display("FAIL fill_id_valid[%0d]: got %b expected %b", i, id_valid2, (i > 0)); end
            tick();
        end
        // Third offer must not have been taken; head stays 0x100 while stalled.
        for (int k = 0; k < 3; k++) begin
            #1;
            checks += 3;
            if (count2 !== 2'd2)     begin errors++; $display("FAIL fill_count: got %0d expected 2", count2); end
            if (if_ready2 !== 1'b0)  begin errors++; $display("FAIL fill_full_ready: got %b expected 0", if_ready2); end
            if (id_pc2 !== 32'h100)  begin errors++; $display("FAIL fill_head_hold: got %h expected 00000100", id_pc2); end
            tick();
        end
        if_valid = 1'b0;
        id_ready = 1'b1;
        #1;
        checks++;
        if (id_pc2 !== 32'h100) begin errors++; $display("FAIL fill_pop0: got %h expected 00000100", id_pc2); end
        tick();
        checks++;
        if (id_pc2 !== 32'h104) begin errors++; $display("FAIL fill_pop1: got %h expected 00000104", id_pc2); end
        tick();
        checks += 2;
        if (id_valid2 !== 1'b0) begin errors++; $display("FAIL fill_drained: got %b expected 0", id_valid2); end
        if (count2 !== 2'd0)    begin errors++; $display("FAIL fill_drained_count: got %0d expected 0", count2); end
    endtask

    task automatic test_streaming();
        do_reset();
        if_valid = 1'b1;
        id_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if_pc   = 32'(i * 4);
            if_inst = $urandom;
            #1;
            checks += 3;
            if (i == 0) begin
                if (id_valid4 !== 1'b0) begin errors++; $display("FAIL stream_first_valid: got %b expected 0", id_valid4); end
                if (count4 !== 3'd0)    begin errors++; $display("FAIL stream_first_count: got %0d expected 0", count4); end
                if (if_ready4 !== 1'b1) begin errors++; $display("FAIL stream_first_ready: got %b expected 1", if_ready4); end
            end else begin
                if (id_pc4 !== 32'((i - 1) * 4)) begin errors++; $display("FAIL stream_lag[%0d]: got %h expected %h", i, id_pc4, 32'((i - 1) * 4)); end
                if (count4 !== 3'd1) begin errors++; $display("FAIL stream_count[%0d]: got %0d expected 1", i, count4); end
                if (id_valid2 !== 1'b1 || id_pc2 !== 32'((i - 1) * 4)) begin
                    errors++; $display("FAIL stream_d2[%0d]: got valid=%b pc=%h expected valid=1 pc=%h", i, id_valid2, id_pc2, 32'((i - 1) * 4));
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        int pushed;
        int popped;
        int cyc;
        do_reset();
        pushed = 0;
        popped = 0;
        cyc    = 0;
        while (popped < 10 && cyc < 300) begin
            if_valid = (pushed < 10) && ($urandom_range(0, 3) != 0);
            if_pc    = 32'(pushed * 4);
            if_inst  = $urandom;
            id_ready = ($urandom_range(0, 2) == 0);
            #1;
            if (id_valid4 && id_ready) begin
                checks++;
                if (id_pc4 !== 32'(popped * 4)) begin errors++; $display("FAIL wrap_order[%0d]: got %h expected %h", popped, id_pc4, 32'(popped * 4)); end
                popped++;
            end
            checks++;
            if (count4 !== 3'(q4.size())) begin errors++; $display("FAIL wrap_count: got %0d expected %0d", count4, q4.size()); end
            if (if_valid && if_ready4) pushed++;
            tick();
            cyc++;
        end
        checks++;
        if (popped != 10) begin errors++; $display("FAIL wrap_timeout: got %0d pops expected 10", popped); end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        if_valid = 1'b1;
        if_pc    = 32'h300;
        tick();
        if_pc    = 32'h304;
        tick();
        if_valid = 1'b0;
        #1;
        checks++;
        if (count4 !== 3'd2) begin errors++; $display("FAIL flush_pre_count: got %0d expected 2", count4); end
        flush    = 1'b1;
        if_valid = 1'b1;
        id_ready = 1'b1;
        if_pc    = 32'h308;
        #1;
        checks += 4;
        if (if_ready4 !== 1'b0) begin errors++; $display("FAIL flush_if_ready: got %b expected 0", if_ready4); end
        if (id_valid4 !== 1'b0) begin errors++; $display("FAIL flush_id_valid: got %b expected 0", id_valid4); end
        if (id_pc4 !== 32'h0)   begin errors++; $display("FAIL flush_id_pc: got %h expected 0", id_pc4); end
        if (if_ready2 !== 1'b0) begin errors++; $display("FAIL flush_if_ready2: got %b expected 0", if_ready2); end
        tick();
        flush    = 1'b0;
        if_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks += 2;
            if (count4 !== 3'd0)    begin errors++; $display("FAIL flush_post_count: got %0d expected 0", count4); end
            if (id_valid4 !== 1'b0) begin errors++; $display("FAIL flush_reappear: got %b expected 0", id_valid4); end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_random();
        bit          ev2, ev4;
        logic [31:0] ep2, ep4, ei2, ei4;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            rst      = ($urandom_range(0, 79) == 0);
            flush    = ($urandom_range(0, 19) == 0);
            if_valid = ($urandom_range(0, 2) != 0);
            id_ready = ($urandom_range(0, 2) != 0);
            if_pc    = $urandom;
            if_inst  = $urandom;
            if_exc   = 1'($urandom);
            #1;
            ev2 = (q2.size() != 0) && !flush;
            ev4 = (q4.size() != 0) && !flush;
            ep2 = ev2 ? q2[0].pc   : 32'h0;
            ei2 = ev2 ? q2[0].inst : 32'h0;
            ep4 = ev4 ? q4[0].pc   : 32'h0;
            ei4 = ev4 ? q4[0].inst : 32'h0;
            checks += 10;
            if (if_ready2 !== ((q2.size() < 2) && !flush)) begin errors++; $display("FAIL rand_ready2 @%0d: got %b", c, if_ready2); end
            if (if_ready4 !== ((q4.size() < 4) && !flush)) begin errors++; $display("FAIL rand_ready4 @%0d: got %b", c, if_ready4); end
            if (id_valid2 !== ev2) begin errors++; $display("FAIL rand_valid2 @%0d: got %b expected %b", c, id_valid2, ev2); end
            if (id_valid4 !== ev4) begin errors++; $display("FAIL rand_valid4 @%0d: got %b expected %b", c, id_valid4, ev4); end
            if (id_pc2 !== ep2)    begin errors++; $display("FAIL rand_pc2 @%0d: got %h expected %h", c, id_pc2, ep2); end
            if (id_pc4 !== ep4)    begin errors++; $display("FAIL rand_pc4 @%0d: got %h expected %h", c, id_pc4, ep4); end
            if (id_inst2 !== ei2)  begin errors++; $display("FAIL rand_inst2 @%0d: got %h expected %h", c, id_inst2, ei2); end
            if (id_inst4 !== ei4)  begin errors++; $display("FAIL rand_inst4 @%0d: got %h expected %h", c, id_inst4, ei4); end
            if (count2 !== 2'(q2.size())) begin errors++; $display("FAIL rand_count2 @%0d: got %0d expected %0d", c, count2, q2.size()); end
            if (count4 !== 3'(q4.size())) begin errors++; $display("FAIL rand_count4 @%0d: got %0d expected %0d", c, count4, q4.size()); end
`ifdef IF_ID_EXCTAG_EN
            checks++;
            if (id_exc4 !== (ev4 ? q4[0].exc : 1'b0)) begin errors++; $display("FAIL rand_exc4 @%0d: got %b", c, id_exc4); end
`endif
            tick();
        end
        idle_inputs();
    endtask

`ifdef IF_ID_EXCTAG_EN
    task automatic test_exc_tag();
        do_reset();
        if_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if_pc  = 32'h1FC + 32'(i * 4);
            if_exc = (i == 1);
            tick();
        end
        if_valid = 1'b0;
        if_exc   = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (id_exc4 !== (id_valid4 && id_pc4 == 32'h200)) begin
                errors++; $display("FAIL exc_tag[%0d]: got %b with pc %h", i, id_exc4, id_pc4);
            end
            tick();
        end
        idle_inputs();
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        idle_inputs();
        test_reset();
        test_fill();
        test_streaming();
        test_wrap();
        test_flush();
`ifdef IF_ID_EXCTAG_EN
        test_exc_tag();
`endif
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
